// File: rtl/pong_if.sv
// pong_if: game-engine bus; frame_tick, paddle controls and serve in, ball/paddle/score/status out
interface pong_if;
  logic       frame_tick;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic       serve;
  logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic [3:0] score1, score2;
  logic       game_over, playing;
  modport master(output frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
                 input ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, game_over, playing);
  modport slave(input frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
                output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, game_over, playing);
endinterface

// File: rtl/pong_game_engine.sv
// pong_game_engine: per-frame Pong physics/scoring; ports clk, rst_n (sync, active-low), bus (pong_if.slave: controls in, positions/scores/status out)
module pong_game_engine #(
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_DELAY  = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic   clk,
  input logic   rst_n,
  pong_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  state_t st, st_n;
  logic [9:0] bx, by, p1, p2, bx_n, by_n, p1_n, p2_n, vy, pad;
  logic [3:0] s1, s2, s1_n, s2_n;
  logic [7:0] cnt, cnt_n;
  logic dx, dy, dx_n, dy_n, serve_q, pend, go, vdy, wall, hit, won;
  function automatic logic [9:0] step_pad(input logic [9:0] p, input logic up, input logic dn);
    return (up && !dn) ? (p < 10'(PADDLE_SPEED) ? 10'd0 : p - 10'(PADDLE_SPEED)) :
           (dn && !up) ? (p > 10'(407 - PADDLE_SPEED) ? 10'd407 : p + 10'(PADDLE_SPEED)) : p;
  endfunction
  // a serve edge seen on any cycle stays pending until the next frame tick consumes it
  assign go   = pend | (bus.serve & ~serve_q);
  // vdy: true when the vertical step bounces off a wall
  assign vdy  = dy ? (by + 10'(BALL_SPEED) >= 10'd472) : (by <= 10'(BALL_SPEED));
  assign vy   = dy ? (vdy ? 10'd472 : by + 10'(BALL_SPEED)) : (vdy ? 10'd0 : by - 10'(BALL_SPEED));
  assign wall = dx ? (bx >= 10'(592 - BALL_SPEED)) : (bx <= 10'(41 + BALL_SPEED));
  assign pad  = dx ? p2 : p1;
  assign hit  = (by + 10'd7 >= pad) && (by <= pad + 10'd72);
  assign won  = (dx ? s1 : s2) + 4'd1 == 4'(WIN_SCORE);
  always_comb begin
    st_n = st;
    bx_n = bx;
    by_n = by;
    dx_n = dx;
    dy_n = dy;
    s1_n = s1;
    s2_n = s2;
    cnt_n = cnt;
    p1_n = st == OVER ? p1 : step_pad(p1, bus.p1_up, bus.p1_down);
    p2_n = st == OVER ? p2 : step_pad(p2, bus.p2_up, bus.p2_down);
    if (st == IDLE && go) st_n = PLAY;
    if (st == PLAY) begin
      by_n = vy;
      dy_n = dy ^ vdy;
      if (!wall) bx_n = dx ? bx + 10'(BALL_SPEED) : bx - 10'(BALL_SPEED);
      else if (hit) begin
        bx_n = dx ? 10'd592 : 10'd41;
        dx_n = ~dx;
      end else begin
        // miss: ball recentres and keeps heading toward the player who lost the point
        bx_n = 10'd316;
        by_n = 10'd236;
        s1_n = dx ? s1 + 4'd1 : s1;
        s2_n = dx ? s2 : s2 + 4'd1;
        cnt_n = 8'(SERVE_DELAY);
        st_n = won ? OVER : PAUSE;
      end
    end
    if (st == PAUSE) begin
      cnt_n = cnt - 8'(cnt != 8'd0);
      st_n = cnt <= 8'd1 ? PLAY : PAUSE;
    end
    if (st == OVER && go) begin
      s1_n = '0;
      s2_n = '0;
      bx_n = 10'd316;
      by_n = 10'd236;
      dx_n = 1'b1;
      dy_n = 1'b1;
      st_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      bx <= 10'd316;
      by <= 10'd236;
      p1 <= 10'd204;
      p2 <= 10'd204;
      s1 <= '0;
      s2 <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
      cnt <= '0;
      serve_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      serve_q <= bus.serve;
      pend <= bus.frame_tick ? 1'b0 : go;
      if (bus.frame_tick) begin
        st <= st_n;
        bx <= bx_n;
        by <= by_n;
        p1 <= p1_n;
        p2 <= p2_n;
        s1 <= s1_n;
        s2 <= s2_n;
        dx <= dx_n;
        dy <= dy_n;
        cnt <= cnt_n;
      end
    end
  end
  assign bus.ball_x    = bx;
  assign bus.ball_y    = by;
  assign bus.paddle1_y = p1;
  assign bus.paddle2_y = p2;
  assign bus.score1    = s1;
  assign bus.score2    = s2;
  assign bus.game_over = st == OVER;
  assign bus.playing   = st == PLAY;
endmodule
